// File: rtl/sd_write_if.sv
// Host/card-facing bundle of the CMD24 write engine: request, byte source and SPI lines.
// The engine attaches as master; the host/card side (mux or bench) attaches as slave.
interface sd_write_if;
  logic        init;
  logic        write_req;
  logic [31:0] addr;
  logic [7:0]  wr_data;
  logic        data_rd;
  logic        SD_DATAOUT;
  logic        SD_DATAIN;
  logic        SD_CS;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic [7:0]  r1;

  modport master (
    input  init, write_req, addr, wr_data, SD_DATAOUT,
    output data_rd, SD_DATAIN, SD_CS, busy, done, err, err_code, r1
  );
  modport slave (
    output init, write_req, addr, wr_data, SD_DATAOUT,
    input  data_rd, SD_DATAIN, SD_CS, busy, done, err, err_code, r1
  );
endinterface

// File: rtl/sd_write.sv
// SPI-mode SD single-block write (CMD24): command, R1, token + 512 bytes + CRC16, data response, busy wait.
// Outputs are registered on the falling SD_CLK edge one clock behind the accepting edge; no request queueing.
module sd_write #(
  parameter int CMD_TIMEOUT   = 128,
  parameter int DRESP_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT  = 65535
) (
  input  logic       SD_CLK,
  input  logic       rst_n,
  sd_write_if.master bus
);
  localparam int T01  = (CMD_TIMEOUT > DRESP_TIMEOUT) ? CMD_TIMEOUT : DRESP_TIMEOUT;
  localparam int TMAX = (T01 > BUSY_TIMEOUT) ? T01 : BUSY_TIMEOUT;
  localparam int CW   = ($clog2(TMAX + 1) > 6) ? $clog2(TMAX + 1) : 6;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_CMD_RESP, S_R1, S_GAP, S_TOKEN,
    S_DATA, S_CRC, S_DRESP, S_DTOK, S_BUSY, S_FINISH
  } state_t;

  state_t        r_state, w_state;
  logic [47:0]   r_sr, w_sr;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [8:0]    r_byte, w_byte;
  logic [15:0]   r_crc, w_crc;
  logic          r_miso;
  logic          r_cs, w_cs;
  logic          r_dout, w_dout;
  logic          r_rd, w_rd;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_err, w_err;
  logic [2:0]    r_err_code, w_err_code, w_fail_code;
  logic [7:0]    r_r1, w_r1, w_r1_byte;
  logic          w_fail, w_ok, w_bit;

  // MISO is captured on the rising edge and consumed by the FSM on the next falling edge.
  always_ff @(posedge SD_CLK or negedge rst_n) begin
    if (!rst_n) r_miso <= 1'b1;
    else        r_miso <= bus.SD_DATAOUT;
  end

  always_comb begin
    w_state     = r_state;
    w_sr        = r_sr;
    w_cnt       = r_cnt;
    w_byte      = r_byte;
    w_crc       = r_crc;
    w_cs        = 1'b0;
    w_dout      = 1'b1;
    w_rd        = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_err_code  = r_err_code;
    w_r1        = r_r1;
    w_fail      = 1'b0;
    w_fail_code = 3'd0;
    w_ok        = 1'b0;
    w_bit       = 1'b0;
    w_r1_byte   = {r_sr[6:0], r_miso};
    unique case (r_state)
      S_IDLE: begin
        w_cs   = 1'b1;
        w_busy = 1'b0;
        if (bus.init && bus.write_req) begin
          w_sr       = {8'h58, bus.addr, 8'hFF};
          w_cnt      = '0;
          w_err_code = 3'd0;
          w_state    = S_CMD;
        end
      end
      S_CMD: begin
        w_dout = r_sr[47];
        w_sr   = {r_sr[46:0], 1'b1};
        w_cnt  = r_cnt + CW'(1);
        if (r_cnt == CW'(47)) begin
          w_cnt   = '0;
          w_state = S_CMD_RESP;
        end
      end
      S_CMD_RESP: begin
        // The R1 start bit is its own MSB (always 0), so it is the first captured bit.
        if (!r_miso) begin
          w_sr[7:0] = 8'h00;
          w_cnt     = CW'(1);
          w_state   = S_R1;
        end else if (r_cnt == CW'(CMD_TIMEOUT - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = 3'd2;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_R1: begin
        w_sr[7:0] = w_r1_byte;
        w_cnt     = r_cnt + CW'(1);
        if (r_cnt == CW'(7)) begin
          w_r1  = w_r1_byte;
          w_cnt = '0;
          if (w_r1_byte == 8'h00) begin
            w_state = S_GAP;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = 3'd1;
          end
        end
      end
      S_GAP: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(7)) begin
          w_cnt        = '0;
          w_sr[47:40]  = 8'hFE;
          w_state      = S_TOKEN;
        end
      end
      S_TOKEN: begin
        w_dout = r_sr[47];
        w_sr   = {r_sr[46:0], 1'b1};
        w_cnt  = r_cnt + CW'(1);
        if (r_cnt == CW'(7)) begin
          w_rd    = 1'b1;
          w_cnt   = '0;
          w_byte  = '0;
          w_crc   = '0;
          w_state = S_DATA;
        end
      end
      S_DATA: begin
        // Bit 7 of each byte comes straight from wr_data; the rest are shifted out of r_sr.
        w_bit       = (r_cnt[2:0] == 3'd0) ? bus.wr_data[7] : r_sr[47];
        w_sr[47:40] = (r_cnt[2:0] == 3'd0) ? {bus.wr_data[6:0], 1'b1} : {r_sr[46:40], 1'b1};
        w_dout      = w_bit;
        w_crc       = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ w_bit) ? 16'h1021 : 16'h0000);
        if (r_cnt[2:0] == 3'd7) begin
          w_cnt  = '0;
          w_byte = r_byte + 9'd1;
          if (r_byte == 9'd511) w_state = S_CRC;
          else                  w_rd    = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_CRC: begin
        w_dout = r_crc[15];
        w_crc  = {r_crc[14:0], 1'b0};
        w_cnt  = r_cnt + CW'(1);
        if (r_cnt == CW'(15)) begin
          w_cnt   = '0;
          w_state = S_DRESP;
        end
      end
      S_DRESP: begin
        if (!r_miso) begin
          w_cnt   = '0;
          w_state = S_DTOK;
        end else if (r_cnt == CW'(DRESP_TIMEOUT - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = 3'd3;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DTOK: begin
        // Three status bits are shifted in; the fourth sample is the end bit.
        w_sr[3:0] = {r_sr[2:0], r_miso};
        w_cnt     = r_cnt + CW'(1);
        if (r_cnt == CW'(3)) begin
          w_cnt = '0;
          if (r_sr[2:0] == 3'b010) begin
            w_state = S_BUSY;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = (r_sr[2:0] == 3'b101) ? 3'd4 : 3'd5;
          end
        end
      end
      S_BUSY: begin
        if (r_miso) begin
          w_ok = 1'b1;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = 3'd6;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_FINISH: begin
        w_cs    = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        w_cs    = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
    // Done and error cycles share S_FINISH: CS released for one clock with the pulse, then IDLE.
    if (w_fail) begin
      w_cs       = 1'b1;
      w_dout     = 1'b1;
      w_err      = 1'b1;
      w_err_code = w_fail_code;
      w_state    = S_FINISH;
    end
    if (w_ok) begin
      w_cs    = 1'b1;
      w_dout  = 1'b1;
      w_done  = 1'b1;
      w_state = S_FINISH;
    end
  end

  always_ff @(negedge SD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sr       <= '1;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_crc      <= '0;
      r_cs       <= 1'b1;
      r_dout     <= 1'b1;
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
      r_r1       <= 8'hFF;
    end else begin
      r_state    <= w_state;
      r_sr       <= w_sr;
      r_cnt      <= w_cnt;
      r_byte     <= w_byte;
      r_crc      <= w_crc;
      r_cs       <= w_cs;
      r_dout     <= w_dout;
      r_rd       <= w_rd;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      r_r1       <= w_r1;
    end
  end

  assign bus.SD_CS     = r_cs;
  assign bus.SD_DATAIN = r_dout;
  assign bus.data_rd   = r_rd;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.r1        = r_r1;
endmodule

// File: doc/sd_write.md
# sd_write

SPI-mode SD card single-block write engine (CMD24), the transmit-direction counterpart of the block read path. After card initialisation it sends CMD24 with a 32-bit block address and checks the R1 response. It then streams a start token, 512 data bytes pulled from an upstream byte source and a computed CRC16, and decodes the card's data-response token. It waits out the card busy period and reports done or a coded error. It shares SD_CS/SD_DATAIN with the other SD engines through the top-level mux and owns them only while busy.

## Interface
- CMD_TIMEOUT, 128: clocks allowed after the command for an R1 start bit.
- DRESP_TIMEOUT, 16: clocks allowed after the CRC for a data-response start bit.
- BUSY_TIMEOUT, 65535: clocks allowed for the card to release busy (MISO high).

Ports:
- SD_CLK  in  1  the single clock; all outputs change on falling edge, SD_DATAOUT sampled on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init  in  1  card initialised; write_req ignored while low.
- write_req  in  1  start a block write; sampled in IDLE only.
- addr  in  32  block address, captured with write_req.
- wr_data  in  8  next data byte (MSB sent first).
- data_rd  out  1  one-cycle byte request; 512 per block.
- SD_DATAOUT  in  1  card MISO.
- SD_DATAIN  out  1  card MOSI; idles high.
- SD_CS  out  1  chip select, active low.
- busy  out  1  high from write_req acceptance to return to IDLE.
- done  out  1  one-cycle pulse, successful write.
- err  out  1  one-cycle pulse, failed write.
- err_code  out  3  0 none, 1 R1 non-zero, 2 R1 timeout, 3 data-response timeout, 4 CRC reject (101), 5 write error (110 or other), 6 busy timeout; held until next request.
- r1  out  8  last received R1 byte.

## Operation
- Reset values: SD_CS=1, SD_DATAIN=1, data_rd=0, busy=0, done=0, err=0, err_code=0, r1=8'hFF, state IDLE.
- IDLE: SD_CS=1, SD_DATAIN=1. If init & write_req, load the frame {8'h58, addr, 8'hFF} (CRC7 byte ignored in SPI mode, stop bit=1), then go to CMD.
- CMD: SD_CS=0. Shift 48 bits MSB first, then go to CMD_RESP with SD_DATAIN=1.
- CMD_RESP: the first rising edge with SD_DATAOUT=0 starts an 8-bit capture into r1.
  - r1==0: go to GAP.
  - r1!=0: error 1.
  - No start bit within CMD_TIMEOUT clocks: error 2.
- GAP: 8 clocks of SD_DATAIN=1. TOKEN: send 8'hFE.
- DATA: 512 bytes MSB first.
  - data_rd is high during bit 0 of the token and during bit 0 of bytes 0..510.
  - wr_data is loaded at the falling edge that ends the data_rd cycle.
- CRC: CRC16-CCITT (x^16+x^12+x^5+1, init 0) is computed over the 4096 data bits as they are sent. Transmit it MSB first, 16 bits.
- DRESP: SD_DATAIN=1.
  - The first 0 on MISO within DRESP_TIMEOUT starts the token; capture the next 4 bits, giving status[2:0] plus the end bit.
  - status 010: go to BUSY. 101: error 4. Anything else: error 5.
  - No start bit within DRESP_TIMEOUT: error 3.
- BUSY: wait for SD_DATAOUT sampled 1, then go to FINISH.
  - If that does not happen within BUSY_TIMEOUT clocks: error 6.
- FINISH: one cycle with SD_CS=1 and done=1, then IDLE.
- Error path: one cycle with SD_CS=1, err=1 and err_code set, then IDLE.
- write_req while busy is ignored (no queueing).
- Reset mid-transfer: outputs return to reset values immediately (async); no partial frame resumes.

## Timing
- Falling edge N samples write_req=1 in IDLE. At edge N+1: busy=1, SD_CS=0, SD_DATAIN=frame bit 47. Frame bit k is driven from edge N+48-k.
- Timeout counters start at the first clock of the respective wait state and count clock periods. Exactly TIMEOUT clocks with no event counts as a timeout.
- Response bits are sampled on rising edges and acted on at the following falling edge.
- Data-phase bit rate is one bit per SD_CLK, with no gaps between token, data and CRC.
- Minimum transaction: 48 cmd + R1 (at least 8) + 8 gap + 8 token + 4096 data + 16 CRC + token (at least 5) + busy, plus 1 finish clock.
- done and err are never high together; each is exactly one cycle wide.

## Test plan
- Block of all 8'hFF, addr=32'h0000_0010, card R1=0x00 after 8 clocks, data token 8'hE5, busy for 100 clocks:
  - Required MOSI: 58 00 00 00 10 FF, then FE, 512×FF, then CRC 7F A1.
  - data_rd pulses exactly 512 times; done pulses once; err_code=0.
- Incrementing bytes 0x00..0xFF twice: CRC field equals the reference-model CRC16. Byte order on MOSI matches the upstream order.
- Card returns R1=0x04 → err pulse, err_code=1, r1=0x04, no FE token sent, SD_CS=1 next cycle.
- MISO held high after CMD24 → err_code=2 after exactly 128 clocks. Data token 8'hEB (status 101) → err_code=4.
- Card holds MISO low past BUSY_TIMEOUT (override to 200) → err_code=6. write_req pulsed during a transfer is ignored.
- rst_n dropped during byte 100 → SD_CS=1, SD_DATAIN=1, busy=0 without waiting for a clock edge. A new write after release completes normally.
